// File: rtl/perf_pkg.sv
// Shared types, default widths and helpers for the performance counter bank.
package perf_pkg;

    // Per-channel counting mode.
    typedef enum logic {
        PERF_LEVEL = 1'b0,
        PERF_EDGE  = 1'b1
    } perf_mode_t;

    localparam int unsigned PERF_NUM_CH_DEF  = 8;
    localparam int unsigned PERF_CNT_W_DEF   = 32;
    localparam int unsigned PERF_WD_W_DEF    = 32;

    // Channel-select width; never narrower than one bit so a single-channel bank still has a port.
    function automatic int unsigned perf_sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_counter_ch.sv
// One event channel: edge history, saturating counter, snapshot register and sticky saturation flag.
module perf_counter_ch
    import perf_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = PERF_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 event_i,
    input  logic                 mode_i,
    input  logic                 clear,
    input  logic                 snap,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic [CNT_WIDTH-1:0] snap_o,
    output logic                 sat_o
);

    logic                 prev_q, prev_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] snap_q, snap_d;
    logic                 sat_q, sat_d;
    logic                 inc;
    perf_mode_t           mode;

    assign mode = perf_mode_t'(mode_i);

    // Next-state: edge history always tracks the raw event; clear beats increment, increment at all-ones saturates.
    always_comb begin
        prev_d = event_i;
        cnt_d  = cnt_q;
        snap_d = snap_q;
        sat_d  = sat_q;
        inc    = 1'b0;

        if (mode == PERF_EDGE) begin
            inc = enable & event_i & ~prev_q;
        end else begin
            inc = enable & event_i;
        end

        // Snapshot takes the registered count, so it sees pre-clear / pre-increment values.
        if (snap) begin
            snap_d = cnt_q;
        end

        if (clear) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (inc) begin
            if (cnt_q == {CNT_WIDTH{1'b1}}) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
            snap_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
            sat_q  <= sat_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign snap_o = snap_q;
    assign sat_o  = sat_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Multi-channel event counter bank with atomic snapshot, global clear, read muxes and a loadable watchdog.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter  int unsigned NUM_CH    = PERF_NUM_CH_DEF,
    parameter  int unsigned CNT_WIDTH = PERF_CNT_W_DEF,
    parameter  int unsigned WD_WIDTH  = PERF_WD_W_DEF,
    localparam int unsigned SEL_W     = perf_sel_width(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM_CH-1:0]    event_i,
    input  logic [NUM_CH-1:0]    mode_i,
    input  logic                 clear,
    input  logic                 snap,
    input  logic [SEL_W-1:0]     rd_sel,
    output logic [CNT_WIDTH-1:0] rd_live,
    output logic [CNT_WIDTH-1:0] rd_snap,
    output logic [NUM_CH-1:0]    sat_o,
    input  logic                 wd_load,
    input  logic [WD_WIDTH-1:0]  wd_value,
    output logic                 wd_expired
);

    logic [CNT_WIDTH-1:0] live_cnt [NUM_CH];
    logic [CNT_WIDTH-1:0] snap_cnt [NUM_CH];

    logic [WD_WIDTH-1:0]  wd_cnt_q, wd_cnt_d;
    logic                 armed_q, armed_d;

    // Per-channel counters; clear and snap fan out to every channel so capture is atomic.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        perf_counter_ch #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .enable  (enable),
            .event_i (event_i[i]),
            .mode_i  (mode_i[i]),
            .clear   (clear),
            .snap    (snap),
            .cnt_o   (live_cnt[i]),
            .snap_o  (snap_cnt[i]),
            .sat_o   (sat_o[i])
        );
    end

    // Read muxes; a select beyond the last channel reads as zero.
    always_comb begin
        rd_live = '0;
        rd_snap = '0;
        if (32'(rd_sel) < NUM_CH) begin
            rd_live = live_cnt[rd_sel];
            rd_snap = snap_cnt[rd_sel];
        end
    end

    // Watchdog next-state: load wins; otherwise count down while armed, enabled and non-zero.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        armed_d  = armed_q;
        if (wd_load) begin
            wd_cnt_d = wd_value;
            armed_d  = 1'b1;
        end else if (armed_q && enable && (wd_cnt_q != '0)) begin
            wd_cnt_d = wd_cnt_q - WD_WIDTH'(1);
        end
    end

    // Watchdog registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            armed_q  <= armed_d;
        end
    end

    assign wd_expired = armed_q & (wd_cnt_q == '0);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed scoreboard bench for perf_counter_bank: stimulus queues expectations, a negedge monitor checks them.
module tb_perf_counter_bank;

    localparam int F_LIVE = 0;
    localparam int F_SNAP = 1;
    localparam int F_SAT  = 2;
    localparam int F_WD   = 3;

    typedef struct {
        int          cyc;
        int          dut;
        int          field;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    // Main instance: 6 channels, 32-bit counters, 16-bit watchdog.
    logic [5:0]  ev, mode, sat_m;
    logic        clear, snap;
    logic [2:0]  sel_m;
    logic [31:0] live_m, snapv_m;
    logic        wd_load;
    logic [15:0] wd_value;
    logic        wd_exp_m;

    // Narrow instance: 2 channels, 4-bit counters for saturation.
    logic [1:0]  ev4, mode4, sat4;
    logic        clear4, snap4, sel4;
    logic [3:0]  live4, snapv4;
    logic        wd_load4;
    logic [7:0]  wd_value4;
    logic        wd_exp4;

    perf_counter_bank #(.NUM_CH(6), .CNT_WIDTH(32), .WD_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .event_i(ev), .mode_i(mode),
        .clear(clear), .snap(snap), .rd_sel(sel_m), .rd_live(live_m), .rd_snap(snapv_m),
        .sat_o(sat_m), .wd_load(wd_load), .wd_value(wd_value), .wd_expired(wd_exp_m)
    );

    perf_counter_bank #(.NUM_CH(2), .CNT_WIDTH(4), .WD_WIDTH(8)) u_dut4 (
        .clk(clk), .rst(rst), .enable(enable), .event_i(ev4), .mode_i(mode4),
        .clear(clear4), .snap(snap4), .rd_sel(sel4), .rd_live(live4), .rd_snap(snapv4),
        .sat_o(sat4), .wd_load(wd_load4), .wd_value(wd_value4), .wd_expired(wd_exp4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue an expectation for the outputs visible in the current cycle.
    task automatic chk(input int dut, input int field, input int sel, input logic [31:0] val,
                       input string name);
        exp_t e;
        if (field == F_LIVE || field == F_SNAP) begin
            if (dut == 0) sel_m = 3'(sel);
            else          sel4  = 1'(sel);
        end
        e.cyc = cyc; e.dut = dut; e.field = field; e.val = val; e.name = name;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] actual(input int dut, input int field);
        logic [31:0] a;
        a = '0;
        if (dut == 0) begin
            case (field)
                F_LIVE:  a = live_m;
                F_SNAP:  a = snapv_m;
                F_SAT:   a = 32'(sat_m);
                default: a = 32'(wd_exp_m);
            endcase
        end else begin
            case (field)
                F_LIVE:  a = 32'(live4);
                F_SNAP:  a = 32'(snapv4);
                F_SAT:   a = 32'(sat4);
                default: a = 32'(wd_exp4);
            endcase
        end
        return a;
    endfunction

    // Monitor: retire every expectation due in this cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] a;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            a = actual(e.dut, e.field);
            n_vec++;
            if (e.cyc != cyc || a !== e.val) begin
                n_err++;
                $display("FAIL %s: got %0d, expected %0d (due cyc %0d, now %0d)",
                         e.name, a, e.val, e.cyc, cyc);
            end
        end
    end

    initial begin
        int pat [7] = '{1, 1, 0, 1, 0, 1, 1};
        rst = 1'b1; enable = 1'b0; ev = '0; mode = '0; clear = 1'b0; snap = 1'b0;
        sel_m = '0; wd_load = 1'b0; wd_value = '0;
        ev4 = '0; mode4 = '0; clear4 = 1'b0; snap4 = 1'b0; sel4 = 1'b0;
        wd_load4 = 1'b0; wd_value4 = '0;

        // Reset state
        step(); step();
        chk(0, F_LIVE, 0, 0, "rst_live0");
        chk(0, F_SAT,  0, 0, "rst_sat");
        chk(0, F_WD,   0, 0, "rst_wd");
        chk(1, F_LIVE, 0, 0, "rst_live4");
        step();
        chk(0, F_SNAP, 0, 0, "rst_snap0");
        rst = 1'b0; enable = 1'b1;

        // Level mode, ch0: five high cycles
        ev[0] = 1'b1;
        repeat (5) step();
        ev[0] = 1'b0;
        chk(0, F_LIVE, 0, 5, "lvl_ch0");
        chk(0, F_SAT,  0, 0, "lvl_no_sat");
        step();

        // Same pattern: ch1 edge mode, ch3 level mode
        mode[1] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ev[1] = 1'(pat[i]);
            ev[3] = 1'(pat[i]);
            step();
        end
        ev[1] = 1'b0; ev[3] = 1'b0;
        chk(0, F_LIVE, 1, 3, "edge_ch1");
        step();
        chk(0, F_LIVE, 3, 5, "lvl_ch3");
        step();

        // Mode switch to edge while event already high: no count until it re-rises
        ev[4] = 1'b1;
        step(); step();
        mode[4] = 1'b1;
        step(); step();
        ev[4] = 1'b0;
        step();
        ev[4] = 1'b1;
        step();
        ev[4] = 1'b0;
        chk(0, F_LIVE, 4, 3, "mode_switch_ch4");
        step();

        // Saturation on the 4-bit instance
        ev4[0] = 1'b1;
        repeat (15) step();
        chk(1, F_LIVE, 0, 15, "sat4_at_max");
        chk(1, F_SAT,  0, 0,  "sat4_not_yet");
        repeat (5) step();
        ev4[0] = 1'b0;
        chk(1, F_LIVE, 0, 15, "sat4_hold");
        chk(1, F_SAT,  0, 1,  "sat4_set");
        clear4 = 1'b1;
        step();
        clear4 = 1'b0;
        chk(1, F_LIVE, 0, 0, "sat4_clear_live");
        chk(1, F_SAT,  0, 0, "sat4_clear_flag");
        step();

        // Snap and clear together with a concurrent event on ch2
        ev[2] = 1'b1;
        repeat (7) step();
        chk(0, F_LIVE, 2, 7, "ch2_pre");
        snap = 1'b1; clear = 1'b1;
        step();
        snap = 1'b0; clear = 1'b0; ev[2] = 1'b0;
        chk(0, F_LIVE, 2, 0, "ch2_cleared");
        step();
        chk(0, F_SNAP, 2, 7, "ch2_snap");
        step();
        chk(0, F_SNAP, 0, 5, "ch0_snap");
        step();
        chk(0, F_SNAP, 1, 3, "ch1_snap");
        step();
        chk(0, F_LIVE, 0, 0, "ch0_cleared");
        step();

        // Watchdog load 10, enable high
        wd_value = 16'd10; wd_load = 1'b1;
        step();
        wd_load = 1'b0;
        for (int k = 0; k < 13; k++) begin
            chk(0, F_WD, 0, 32'(k >= 10), "wd10");
            step();
        end

        // Reload at expiry, then freeze for 3 cycles mid-count
        wd_load = 1'b1;
        step();
        wd_load = 1'b0;
        for (int k = 0; k < 15; k++) begin
            enable = !(k >= 2 && k <= 4);
            chk(0, F_WD, 0, 32'(k >= 13), "wd13_gap");
            step();
        end
        enable = 1'b1;

        // Load of zero expires on the next cycle
        wd_value = 16'd0; wd_load = 1'b1;
        step();
        wd_load = 1'b0;
        chk(0, F_WD, 0, 1, "wd_load0");
        step();

        // Build up state: ch5 to 100, narrow instance saturated, watchdog armed
        wd_value = 16'd1000; wd_load = 1'b1; ev[5] = 1'b1; ev4[0] = 1'b1;
        step();
        wd_load = 1'b0;
        repeat (99) step();
        ev[5] = 1'b0; ev4[0] = 1'b0;
        chk(0, F_LIVE, 5, 100, "ch5_100");
        chk(1, F_SAT,  0, 1,   "sat4_pre_rst");
        chk(0, F_WD,   0, 0,   "wd_running");
        snap = 1'b1;
        step();
        snap = 1'b0;
        chk(0, F_SNAP, 5, 100, "ch5_snap");
        step();
        chk(0, F_LIVE, 6, 0, "oor_live");
        step();
        chk(0, F_SNAP, 7, 0, "oor_snap");
        step();

        // Reset overrides all activity in the same cycle
        rst = 1'b1; ev[5] = 1'b1; ev4[0] = 1'b1; snap = 1'b1; wd_load = 1'b1; wd_value = 16'd0;
        step();
        rst = 1'b0; ev = '0; ev4 = '0; snap = 1'b0; wd_load = 1'b0;
        chk(0, F_LIVE, 5, 0, "rst_live5");
        chk(1, F_SAT,  0, 0, "rst_sat4");
        chk(0, F_WD,   0, 0, "rst_wd_mid");
        step();
        chk(0, F_SNAP, 5, 0, "rst_snap5");
        chk(1, F_LIVE, 0, 0, "rst_live4_mid");
        step();
        chk(0, F_WD,   0, 0, "rst_wd_disarmed");
        step(); step();

        if (sb_q.size() != 0) begin
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
            n_err += sb_q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Synthesizable multi-channel event counter bank with a watchdog timer, generalising the ad-hoc branch/mispredict/prefetch counters and cycle timeout used in the mp4 bench.
- Per-channel level or rising-edge counting, saturation with sticky flags, global clear, atomic snapshot, and a loadable down-counting watchdog.
- Instantiated inside mp4; event lines come from datapath, hazard control, prefetcher and caches. Read from the bench or a CSR path.

Parameters:
NUM_CH, 8, number of independent event channels (1..32)
CNT_WIDTH, 32, width of each channel counter and snapshot register
WD_WIDTH, 32, width of watchdog down-counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
enable  input  1  global count enable; gates channel increments and watchdog decrement
event_i  input  NUM_CH  per-channel event strobe
mode_i  input  NUM_CH  per-channel mode: 0 = level (count every high cycle), 1 = edge (count 0->1 transitions)
clear  input  1  zero all counters and sticky saturation flags
snap  input  1  copy all live counters into snapshot registers
rd_sel  input  $clog2(NUM_CH) (min 1)  channel select for read ports
rd_live  output  CNT_WIDTH  live counter of channel rd_sel (combinational)
rd_snap  output  CNT_WIDTH  snapshot register of channel rd_sel (combinational)
sat_o  output  NUM_CH  sticky per-channel saturation flags
wd_load  input  1  load watchdog with wd_value and arm it
wd_value  input  WD_WIDTH  watchdog load value in cycles
wd_expired  output  1  watchdog armed and count reached zero

Behaviour:
- Reset (rst high at posedge): all counters, snapshots, sat_o, edge-history regs, watchdog count and armed flag go to 0. wd_expired = 0. rd_live/rd_snap = 0.
- Edge history prev[i] <= event_i[i] every cycle, independent of enable, clear and snap. clear does not touch prev.
- Increment condition inc[i] = enable & (mode_i[i] ? (event_i[i] & ~prev[i]) : event_i[i]).
- Counter update, priority high to low: clear -> 0 and sat[i] <= 0; inc[i] with cnt == all-ones -> hold all-ones, sat[i] <= 1; inc[i] -> cnt + 1; otherwise hold.
- Saturation holds the counter at all-ones, with no wrap. sat[i] stays set until clear or rst.
- Increment latency is 1 cycle: an event in cycle N is visible on rd_live in cycle N+1.
- Mode change mid-run takes effect in the same cycle. An edge-mode channel whose event was already high before the switch does not count until it falls and rises again.
- snap: snapshot[i] <= live cnt[i] as registered at that posedge, excluding that cycle's increment. All channels are captured atomically.
- snap and clear in the same cycle: snapshot captures the pre-clear values, and the counters go to 0. Used for interval sampling.
- rd_sel >= NUM_CH: rd_live = rd_snap = 0.
- Watchdog state: wd_cnt, armed.
  - wd_load: wd_cnt <= wd_value, armed <= 1. Load has priority over decrement and expiry.
  - Otherwise, if armed & enable & wd_cnt != 0: wd_cnt <= wd_cnt - 1.
  - wd_expired = armed & (wd_cnt == 0), combinational from registers. It stays high until the next wd_load or rst.
  - Load of 0 asserts wd_expired the next cycle.
  - Load of V with enable held high asserts wd_expired exactly V cycles after the load cycle's edge.
  - enable low freezes the watchdog. clear does not affect the watchdog.
- rst mid-operation overrides all inputs in that cycle.

Decomposition:
- Package perf_pkg:
  - typedef enum logic {PERF_LEVEL = 1'b0, PERF_EDGE = 1'b1} perf_mode_t
  - localparam default widths
  - sel width helper function: $clog2 with min 1
- Sub-module perf_counter_ch: one channel holding prev, cnt, snapshot and sat, with the priority logic above. Instantiated NUM_CH times via generate.
- Watchdog and read muxes live in the top.

Test Plan:
- Level mode ch0, enable = 1, event high 5 cycles -> rd_live(0) = 5 one cycle after the last event; sat_o = 0.
- Edge mode ch1, event pattern 1,1,0,1,0,1,1 with prev = 0 at start -> count = 3. Same pattern in level mode -> 5.
- CNT_WIDTH = 4 instance, level event 20 cycles -> rd_live = 15, sat_o[0] = 1. Then clear -> rd_live = 0, sat_o[0] = 0 next cycle.
- Count ch2 to 7, then assert snap and clear in the same cycle with event high -> rd_snap(2) = 7, rd_live(2) = 0 next cycle, and the concurrent event is dropped.
- wd_load with wd_value = 10 and enable high:
  - wd_expired rises exactly 10 cycles after load and stays high.
  - With enable dropped for 3 cycles mid-count, it rises at 13 cycles.
  - Reload at expiry -> wd_expired deasserts the next cycle.
- Assert rst while counters = 100 and watchdog armed -> next cycle all counts, snapshots, sat_o and wd_expired = 0. rd_sel = NUM_CH -> rd_live = rd_snap = 0.
